// File: rtl/spi_loopback_pair.sv
// spi_loopback_pair: SPI burst master wired to a 4-byte register-file SPI slave on one clock.
module spi_loopback_slave (
   input  logic clk,
   input  logic reset,
   input  logic cpol,
   input  logic cpha,
   input  logic sclk,
   input  logic mosi,
   input  logic ss,
   output logic miso
);
   logic [2:0] sclk_q, sclk_d, bcnt_q, bcnt_d;
   logic [1:0] mosi_q, mosi_d, ss_q, ss_d, addr_q, addr_d, a;
   logic [6:0] rsh_q, rsh_d, tsh_q, tsh_d;
   logic [7:0] byte_in;
   logic [7:0] regs_q [4];
   logic [7:0] regs_d [4];
   logic       cmd_q, cmd_d, wr_q, wr_d, miso_q, miso_d, lead, smp, shf, wr_now;

   always_comb begin
      sclk_d  = {sclk_q[1:0], sclk};
      mosi_d  = {mosi_q[0], mosi};
      ss_d    = {ss_q[0], ss};
      lead    = sclk_q[1] != cpol;
      smp     = (sclk_q[1] ^ sclk_q[2]) & (lead ^ cpha);
      shf     = (sclk_q[1] ^ sclk_q[2]) & ~(lead ^ cpha);
      byte_in = {rsh_q, mosi_q[1]};
      wr_now  = cmd_q ? wr_q : byte_in[7];
      a       = cmd_q ? addr_q : byte_in[1:0];
      bcnt_d  = bcnt_q;
      rsh_d   = rsh_q;
      tsh_d   = tsh_q;
      cmd_d   = cmd_q;
      wr_d    = wr_q;
      miso_d  = miso_q;
      addr_d  = addr_q;
      regs_d  = regs_q;
      if (ss_q[1]) begin
         bcnt_d = '0;
         cmd_d  = 1'b0;
         tsh_d  = '0;
         miso_d = 1'b0;
      end else if (shf && bcnt_q != 3'd0) begin
         miso_d = tsh_q[6];
         tsh_d  = {tsh_q[5:0], 1'b0};
      end else if (smp) begin
         rsh_d  = byte_in[6:0];
         bcnt_d = bcnt_q + 3'd1;
         // byte boundary: the next read byte is staged here so its MSB leads the next byte
         if (bcnt_q == 3'd7) begin
            cmd_d  = 1'b1;
            wr_d   = wr_now;
            if (cmd_q && wr_q)
               regs_d[addr_q] = byte_in;
            tsh_d  = wr_now ? 7'h00 : regs_q[a][6:0];
            miso_d = ~wr_now & regs_q[a][7];
            addr_d = a + {1'b0, cmd_q | ~wr_now};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_q <= '0;
         mosi_q <= '0;
         ss_q   <= '1;
         bcnt_q <= '0;
         rsh_q  <= '0;
         tsh_q  <= '0;
         cmd_q  <= 1'b0;
         wr_q   <= 1'b0;
         miso_q <= 1'b0;
         addr_q <= '0;
         regs_q <= '{default: 8'h00};
      end else begin
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
         ss_q   <= ss_d;
         bcnt_q <= bcnt_d;
         rsh_q  <= rsh_d;
         tsh_q  <= tsh_d;
         cmd_q  <= cmd_d;
         wr_q   <= wr_d;
         miso_q <= miso_d;
         addr_q <= addr_d;
         regs_q <= regs_d;
      end
   end

   assign miso = miso_q & ~ss;
endmodule

module spi_loopback_pair #(
   parameter int SCLK_HALF = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic [2:0] write_count,
   input  logic [2:0] read_count,
   output logic [7:0] rx_data,
   output logic       done,
   output logic       ready,
   output logic       SCLK,
   output logic       MOSI,
   output logic       SS,
   output logic       MISO
);
   typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, STOP} state_t;
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d, rx_q, rx_d, rx_data_q, rx_data_d;
   logic [6:0] sh_q, sh_d;
   logic [3:0] e_q, e_d;
   logic [2:0] rem_q, rem_d;
   logic       cpol_q, cpol_d, cpha_q, cpha_d, done_q, done_d, ready_q, ready_d;
   logic       sclk_q, sclk_d, mosi_q, mosi_d, ss_q, ss_d, half_end;

   always_comb begin
      half_end  = cnt_q == 8'(SCLK_HALF - 1);
      state_d   = state_q;
      cnt_d     = cnt_q + 8'd1;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      sh_d      = sh_q;
      e_d       = e_q;
      rem_d     = rem_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      done_d    = 1'b0;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ss_d      = ss_q;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            sclk_d = cpol;
            ss_d   = 1'b1;
            mosi_d = 1'b0;
            if (start) begin
               cpol_d  = cpol;
               cpha_d  = cpha;
               rem_d   = tx_data[7] ? write_count : read_count;
               sh_d    = tx_data[6:0];
               mosi_d  = tx_data[7];
               ss_d    = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: if (half_end) begin
            cnt_d   = '0;
            e_d     = '0;
            state_d = XFER;
         end
         XFER: if (half_end) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
            e_d    = e_q + 4'd1;
            // the bit already on MOSI at byte start is never shifted away
            if (e_q[0] == cpha_q)
               rx_d = {rx_q[6:0], MISO};
            else if (e_q != (cpha_q ? 4'd0 : 4'd15)) begin
               mosi_d = sh_q[6];
               sh_d   = {sh_q[5:0], 1'b0};
            end
            if (e_q == 4'd15)
               state_d = GAP;
         end
         GAP: if (cnt_q == 8'd0) begin
            done_d    = 1'b1;
            rx_data_d = rx_q;
         end else begin
            cnt_d = '0;
            if (rem_q != 3'd0) begin
               rem_d   = rem_q - 3'd1;
               sh_d    = tx_data[6:0];
               mosi_d  = tx_data[7];
               e_d     = '0;
               state_d = XFER;
            end else
               state_d = STOP;
         end
         STOP: if (half_end) begin
            cnt_d   = '0;
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
            sclk_d  = cpol;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = state_d == IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         sh_q      <= '0;
         e_q       <= '0;
         rem_q     <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         ss_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         sh_q      <= sh_d;
         e_q       <= e_d;
         rem_q     <= rem_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ss_q      <= ss_d;
      end
   end

   spi_loopback_slave u_slave (
      .clk   (clk),
      .reset (reset),
      .cpol  (cpol_q),
      .cpha  (cpha_q),
      .sclk  (sclk_q),
      .mosi  (mosi_q),
      .ss    (ss_q),
      .miso  (MISO)
   );

   assign rx_data = rx_data_q;
   assign done    = done_q;
   assign ready   = ready_q;
   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign SS      = ss_q;
endmodule

// File: tb/tb_spi_loopback_pair.sv
// tb_spi_loopback_pair: directed bursts through the master/slave pair with hand-computed expectations.
module tb_spi_loopback_pair;
   logic       clk = 1'b0, reset = 1'b0, cpol = 1'b0, cpha = 1'b0, start = 1'b0;
   logic [7:0] tx_data = '0;
   logic [2:0] write_count = '0, read_count = '0;
   logic [7:0] rx_data;
   logic       done, ready, SCLK, MOSI, SS, MISO;
   logic [7:0] wdata [8];
   logic [7:0] rdata [9];
   logic [7:0] exp_rd [4];
   int         n_cmp = 0, n_err = 0, ndone;
   logic       ss_gap;

   always #5 clk = ~clk;

   spi_loopback_pair #(.SCLK_HALF(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .cpol        (cpol),
      .cpha        (cpha),
      .start       (start),
      .tx_data     (tx_data),
      .write_count (write_count),
      .read_count  (read_count),
      .rx_data     (rx_data),
      .done        (done),
      .ready       (ready),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .SS          (SS),
      .MISO        (MISO)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_ss"}, SS, 1);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_sclk"}, SCLK, 0);
      check({tag, "_mosi"}, MOSI, 0);
      check({tag, "_miso"}, MISO, 0);
      check({tag, "_rx"}, rx_data, 0);
   endtask

   // runs one burst; feeds wdata on each done, records rx_data per done, optional async abort
   task automatic burst(input logic [7:0] cmd, input int n, input int abort_at);
      bit fin = 0;
      repeat (2) @(negedge clk);
      tx_data     = cmd;
      write_count = cmd[7] ? 3'(n) : 3'(~n);
      read_count  = cmd[7] ? 3'(~n) : 3'(n);
      start       = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      ndone  = 0;
      ss_gap = 1'b0;
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
         @(negedge clk);
         start = (cyc == 40);
         if (done) begin
            if (ndone < 9) rdata[ndone] = rx_data;
            ndone++;
            if (ndone <= n) tx_data = wdata[ndone-1];
         end
         if (!ready && SS) ss_gap = 1'b1;
         if (ready) fin = 1;
         if (cyc == abort_at) begin
            #2 reset = 1'b0;
            #1 check_idle_reset("abort");
            fin = 1;
         end
      end
      start = 1'b0;
      if (!fin) check("timeout", 0, 1);
   endtask

   initial begin
      #12 check_idle_reset("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cpol = 1'b1;
      cpha = 1'b1;
      for (int i = 0; i < 8; i++) wdata[i] = 8'h11 * (i + 1);
      burst(8'h80, 4, 100);
      @(negedge clk);
      reset = 1'b1;
      cpol = 1'b0;
      cpha = 1'b0;
      burst(8'h00, 4, -1);
      for (int i = 1; i <= 4; i++) check("partial_rd", rdata[i], 0);
      for (int m = 0; m < 4; m++) begin
         cpol = m[1];
         cpha = m[0];
         for (int i = 0; i < 4; i++) wdata[i] = 8'(8'h10 * (i + 1) + m);
         burst(8'h80, 4, -1);
         check("wr_dones", ndone, 5);
         check("wr_ss_low", ss_gap, 0);
         check("wr_sclk_idle", SCLK, cpol);
         check("wr_miso_zero", rdata[4], 0);
         burst(8'h00, 4, -1);
         check("rd_dones", ndone, 5);
         check("rd_ss_low", ss_gap, 0);
         check("rd_sclk_idle", SCLK, cpol);
         check("rd_cmd_rx", rdata[0], 0);
         for (int i = 1; i <= 4; i++) check("rd_data", rdata[i], 8'(8'h10 * i + m));
      end
      cpol = 1'b0;
      cpha = 1'b0;
      burst(8'h03, 2, -1);
      check("wrap_dones", ndone, 3);
      check("wrap_rd0", rdata[1], 8'h43);
      check("wrap_rd1", rdata[2], 8'h13);
      burst(8'h81, 0, -1);
      check("zero_dones", ndone, 1);
      repeat (3) @(negedge clk);
      check("zero_ss_high", SS, 1);
      check("zero_ready", ready, 1);
      burst(8'h00, 4, -1);
      exp_rd = '{8'h13, 8'h23, 8'h33, 8'h43};
      for (int i = 0; i < 4; i++) check("zero_unchanged", rdata[i+1], exp_rd[i]);
      cpol = 1'b1;
      wdata[0] = 8'hA5;
      wdata[1] = 8'h5A;
      burst(8'h83, 2, -1);
      check("wwrap_dones", ndone, 3);
      burst(8'h00, 4, -1);
      exp_rd = '{8'h5A, 8'h23, 8'h33, 8'hA5};
      for (int i = 0; i < 4; i++) check("wwrap_rd", rdata[i+1], exp_rd[i]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
